// File: rtl/nerv_run_ctrl_if.sv
// Run-control bus between the GDB stub / CPU side (master) and nerv_run_ctrl (slave).
// Groups the command, breakpoint-table, retire and stop-event channels.
interface nerv_run_ctrl_if #(
    parameter int XLEN = 32,
    parameter int BPN  = 4
);
    localparam int IW = (BPN > 1) ? $clog2(BPN) : 1;

    logic            cmd_vld;
    logic            cmd_rdy;
    logic [1:0]      cmd_op;

    logic            bp_we;
    logic [IW-1:0]   bp_idx;
    logic            bp_en;
    logic [XLEN-1:0] bp_adr;

    logic            ret_vld;
    logic [XLEN-1:0] ret_pc;
    logic            ret_trap;
    logic            cpu_stall;

    logic            evt_vld;
    logic            evt_rdy;
    logic [1:0]      evt_why;
    logic [XLEN-1:0] evt_pc;

    modport master (
        output cmd_vld, cmd_op, bp_we, bp_idx, bp_en, bp_adr,
               ret_vld, ret_pc, ret_trap, evt_rdy,
        input  cmd_rdy, cpu_stall, evt_vld, evt_why, evt_pc
    );

    modport slave (
        input  cmd_vld, cmd_op, bp_we, bp_idx, bp_en, bp_adr,
               ret_vld, ret_pc, ret_trap, evt_rdy,
        output cmd_rdy, cpu_stall, evt_vld, evt_why, evt_pc
    );
endinterface

// File: rtl/nerv_run_ctrl.sv
// Debug run controller: halts/continues/steps the CPU, checks hardware breakpoints
// on every retirement and reports one stop event at a time to the GDB stub.
module nerv_run_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              BPN        = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    nerv_run_ctrl_if.slave  bus
);
    localparam int IW = (BPN > 1) ? $clog2(BPN) : 1;

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_CONT   = 2'd1;
    localparam logic [1:0] OP_STEP   = 2'd2;

    localparam logic [1:0] WHY_INT   = 2'd0;
    localparam logic [1:0] WHY_BREAK = 2'd1;
    localparam logic [1:0] WHY_STEP  = 2'd2;
    localparam logic [1:0] WHY_TRAP  = 2'd3;

    typedef enum logic [1:0] {
        S_HALTED,
        S_RUN,
        S_STEP,
        S_REPORT
    } state_t;

    state_t          state_reg;
    logic            cmd_rdy_reg;
    logic            cpu_stall_reg;
    logic            evt_vld_reg;
    logic [1:0]      evt_why_reg;
    logic [XLEN-1:0] evt_pc_reg;
    logic [XLEN-1:0] pc_last_reg;

    logic [BPN-1:0]  bp_hit;
    logic            bp_match;

    // Breakpoint table: compares use the contents before any same-cycle write.
    generate
        for (genvar gi = 0; gi < BPN; gi++) begin : g_bp
            logic            en_reg;
            logic [XLEN-1:0] adr_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    en_reg <= 1'b0;
                end else if (bus.bp_we && (bus.bp_idx == IW'(gi))) begin
                    en_reg <= bus.bp_en;
                end
            end

            always_ff @(posedge clk) begin
                if (bus.bp_we && (bus.bp_idx == IW'(gi))) begin
                    adr_reg <= bus.bp_adr;
                end
            end

            assign bp_hit[gi] = en_reg && (adr_reg == bus.ret_pc);
        end
    endgenerate

    assign bp_match = |bp_hit;

    logic            cmd_fire;
    logic            halt_req;
    logic            stop_now;
    logic [1:0]      stop_why;
    logic [XLEN-1:0] stop_pc;

    assign cmd_fire = bus.cmd_vld && cmd_rdy_reg;
    assign halt_req = cmd_fire && (bus.cmd_op == OP_HALT);

    // Stop-cause priority while executing: TRAP > BREAK > STEP > INT.
    always_comb begin
        stop_now = 1'b0;
        stop_why = WHY_INT;
        stop_pc  = pc_last_reg;
        if (state_reg == S_RUN || state_reg == S_STEP) begin
            if (bus.ret_vld) begin
                stop_pc = bus.ret_pc;
                if (bus.ret_trap) begin
                    stop_now = 1'b1;
                    stop_why = WHY_TRAP;
                end else if (bp_match) begin
                    stop_now = 1'b1;
                    stop_why = WHY_BREAK;
                end else if (state_reg == S_STEP) begin
                    stop_now = 1'b1;
                    stop_why = WHY_STEP;
                end else if (halt_req) begin
                    stop_now = 1'b1;
                    stop_why = WHY_INT;
                end
            end else if (halt_req) begin
                stop_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= S_HALTED;
            cmd_rdy_reg   <= 1'b1;
            cpu_stall_reg <= 1'b1;
            evt_vld_reg   <= 1'b0;
            evt_why_reg   <= WHY_INT;
            evt_pc_reg    <= RESET_ADDR;
            pc_last_reg   <= RESET_ADDR;
        end else begin
            if (bus.ret_vld) begin
                pc_last_reg <= bus.ret_pc;
            end
            unique case (state_reg)
                S_HALTED: begin
                    if (cmd_fire) begin
                        case (bus.cmd_op)
                            OP_CONT: begin
                                state_reg     <= S_RUN;
                                cpu_stall_reg <= 1'b0;
                            end
                            OP_STEP: begin
                                state_reg     <= S_STEP;
                                cpu_stall_reg <= 1'b0;
                            end
                            OP_HALT: begin
                                state_reg   <= S_REPORT;
                                cmd_rdy_reg <= 1'b0;
                                evt_vld_reg <= 1'b1;
                                evt_why_reg <= WHY_INT;
                                evt_pc_reg  <= pc_last_reg;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN, S_STEP: begin
                    // Stall rises on the edge after the stopping retirement.
                    if (stop_now) begin
                        state_reg     <= S_REPORT;
                        cpu_stall_reg <= 1'b1;
                        cmd_rdy_reg   <= 1'b0;
                        evt_vld_reg   <= 1'b1;
                        evt_why_reg   <= stop_why;
                        evt_pc_reg    <= stop_pc;
                    end
                end
                S_REPORT: begin
                    if (bus.evt_rdy) begin
                        state_reg   <= S_HALTED;
                        evt_vld_reg <= 1'b0;
                        cmd_rdy_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= S_HALTED;
                    cmd_rdy_reg   <= 1'b1;
                    cpu_stall_reg <= 1'b1;
                    evt_vld_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_rdy   = cmd_rdy_reg;
    assign bus.cpu_stall = cpu_stall_reg;
    assign bus.evt_vld   = evt_vld_reg;
    assign bus.evt_why   = evt_why_reg;
    assign bus.evt_pc    = evt_pc_reg;

endmodule

// File: tb/tb_nerv_run_ctrl.sv
// Bench for nerv_run_ctrl: directed scenarios then random traffic, every cycle checked
// against a transaction-level model (target executing / event pending / last PC / bp table).
module tb_nerv_run_ctrl;
    localparam int XLEN = 32;
    localparam int BPN  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nerv_run_ctrl_if #(.XLEN(XLEN), .BPN(BPN)) bus ();

    nerv_run_ctrl #(.XLEN(XLEN), .BPN(BPN), .RESET_ADDR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model
    bit          m_busy;
    bit          m_single;
    bit          m_evt;
    logic [1:0]  m_why;
    logic [31:0] m_pc;
    logic [31:0] m_last;
    bit          bp_on [BPN];
    logic [31:0] bp_at [BPN];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic idle();
        bus.cmd_vld  = 1'b0;
        bus.cmd_op   = 2'd0;
        bus.bp_we    = 1'b0;
        bus.bp_idx   = '0;
        bus.bp_en    = 1'b0;
        bus.bp_adr   = '0;
        bus.ret_vld  = 1'b0;
        bus.ret_pc   = '0;
        bus.ret_trap = 1'b0;
        bus.evt_rdy  = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] op);
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = op;
    endtask

    task automatic retire(input logic [31:0] pc, input bit trap);
        bus.ret_vld  = 1'b1;
        bus.ret_pc   = pc;
        bus.ret_trap = trap;
    endtask

    // What the controller must do at the coming rising edge, given current inputs.
    task automatic model_edge();
        bit          stop;
        bit          hit;
        bit          halt;
        logic [1:0]  why;
        logic [31:0] pc;
        if (!rst) begin
            m_busy = 0; m_single = 0; m_evt = 0;
            m_why = 2'd0; m_pc = 32'h0; m_last = 32'h0;
            for (int i = 0; i < BPN; i++) bp_on[i] = 0;
            return;
        end
        stop = 0; why = 2'd0; pc = m_last;
        halt = bus.cmd_vld && (bus.cmd_op == 2'd0);
        hit = 0;
        for (int i = 0; i < BPN; i++)
            if (bp_on[i] && bp_at[i] == bus.ret_pc) hit = 1;
        if (m_evt) begin
            if (bus.evt_rdy) m_evt = 0;
        end else if (!m_busy) begin
            if (bus.cmd_vld) begin
                case (bus.cmd_op)
                    2'd0: stop = 1;
                    2'd1: begin m_busy = 1; m_single = 0; end
                    2'd2: begin m_busy = 1; m_single = 1; end
                    default: ;
                endcase
            end
        end else begin
            if (bus.ret_vld) begin
                pc = bus.ret_pc;
                if (bus.ret_trap)   begin stop = 1; why = 2'd3; end
                else if (hit)       begin stop = 1; why = 2'd1; end
                else if (m_single)  begin stop = 1; why = 2'd2; end
                else if (halt)      begin stop = 1; why = 2'd0; end
            end else if (halt) begin
                stop = 1;
            end
        end
        if (stop) begin
            m_busy = 0; m_evt = 1; m_why = why; m_pc = pc;
        end
        if (bus.ret_vld) m_last = bus.ret_pc;
        if (bus.bp_we && int'(bus.bp_idx) < BPN) begin
            bp_on[bus.bp_idx] = bus.bp_en;
            bp_at[bus.bp_idx] = bus.bp_adr;
        end
    endtask

    task automatic tick(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        check({ph, ".stall"},   bus.cpu_stall, !m_busy);
        check({ph, ".cmd_rdy"}, bus.cmd_rdy,   !m_evt);
        check({ph, ".evt_vld"}, bus.evt_vld,   m_evt);
        check({ph, ".evt_why"}, bus.evt_why,   m_why);
        check({ph, ".evt_pc"},  bus.evt_pc,    m_pc);
    endtask

    function automatic logic [31:0] pick_pc();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    initial begin
        logic [31:0] brk_seq [4];
        brk_seq[0] = 32'h4; brk_seq[1] = 32'h8; brk_seq[2] = 32'hC; brk_seq[3] = 32'h10;

        // Reset
        idle(); rst = 1'b0;
        tick("rst"); tick("rst");
        check("rst_spec", {bus.cpu_stall, bus.evt_vld, bus.cmd_rdy, bus.evt_pc}, {1'b1, 1'b0, 1'b1, 32'h0});
        rst = 1'b1;

        // Breakpoint at 0x10
        idle(); bus.bp_we = 1'b1; bus.bp_idx = '0; bus.bp_en = 1'b1; bus.bp_adr = 32'h10;
        tick("bpw");
        idle(); cmd(2'd1); tick("cont");
        for (int i = 0; i < 4; i++) begin
            idle(); retire(brk_seq[i], 0); tick("brk");
        end
        check("brk_spec", {bus.evt_vld, bus.evt_why, bus.evt_pc, bus.cpu_stall}, {1'b1, 2'd1, 32'h10, 1'b1});

        // Backpressure: event held, commands refused
        for (int i = 0; i < 10; i++) begin
            idle(); if (i % 3 == 0) cmd(2'd1); tick("bkp");
        end
        check("bkp_spec", {bus.evt_vld, bus.evt_why, bus.evt_pc, bus.cmd_rdy}, {1'b1, 2'd1, 32'h10, 1'b0});
        idle(); bus.evt_rdy = 1'b1; tick("ack");

        // Single step from 0x10
        idle(); cmd(2'd2); tick("step");
        idle(); retire(32'h14, 0); tick("step");
        check("step_spec", {bus.evt_vld, bus.evt_why, bus.evt_pc}, {1'b1, 2'd2, 32'h14});
        idle(); bus.evt_rdy = 1'b1; tick("ack");

        // Resume: breakpoint not re-hit; then HALT without retire
        idle(); cmd(2'd1); tick("res");
        idle(); retire(32'h14, 0); tick("res");
        idle(); retire(32'h18, 0); tick("res");
        check("res_spec", bus.evt_vld, 1'b0);
        idle(); cmd(2'd0); tick("int");
        check("int_spec", {bus.evt_vld, bus.evt_why, bus.evt_pc}, {1'b1, 2'd0, 32'h18});
        idle(); bus.evt_rdy = 1'b1; tick("ack");

        // Priority: trap + breakpoint + HALT together
        idle(); cmd(2'd1); tick("pri");
        idle(); retire(32'h10, 1); cmd(2'd0); tick("pri");
        check("pri_spec", {bus.evt_vld, bus.evt_why, bus.evt_pc}, {1'b1, 2'd3, 32'h10});
        idle(); bus.evt_rdy = 1'b1; tick("ack");

        // HALT while halted
        idle(); cmd(2'd0); tick("hh");
        check("hh_spec", {bus.evt_vld, bus.evt_why, bus.evt_pc}, {1'b1, 2'd0, 32'h10});
        idle(); bus.evt_rdy = 1'b1; tick("ack");

        // Reset while reporting
        idle(); cmd(2'd0); tick("rrep");
        idle(); rst = 1'b0; tick("rrep");
        check("rrep_spec", bus.evt_vld, 1'b0);
        rst = 1'b1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 4) == 0) cmd(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) begin
                bus.bp_we  = 1'b1;
                bus.bp_idx = 2'($urandom_range(0, BPN - 1));
                bus.bp_en  = 1'($urandom_range(0, 1));
                bus.bp_adr = pick_pc();
            end
            if (m_busy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0))
                retire(pick_pc(), $urandom_range(0, 9) == 0);
            bus.evt_rdy = 1'($urandom_range(0, 1));
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
